// File: rtl/pipeline_mem_pkg.sv
// Shared types for the memory stage: op/size codes, FSM states and size helpers.
package mem_pkg;

    typedef enum logic [1:0] {
        OP_NONE  = 2'd0,
        OP_LOAD  = 2'd1,
        OP_LOADU = 2'd2,
        OP_STORE = 2'd3
    } mem_op_e;

    typedef enum logic [1:0] {
        SZ_BYTE   = 2'd0,
        SZ_HALF   = 2'd1,
        SZ_WORD   = 2'd2,
        SZ_DOUBLE = 2'd3
    } mem_size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    function automatic logic [3:0] size_bytes(input mem_size_e sz);
        return 4'd1 << sz;
    endfunction

    // Codes 4-7 behave as a doubleword access.
    function automatic mem_size_e norm_size(input logic [2:0] code);
        return code[2] ? SZ_DOUBLE : mem_size_e'(code[1:0]);
    endfunction

endpackage

// File: rtl/pipeline_mem_if.sv
// Single-outstanding data-memory port: request valid/ready, response valid only.
interface pipeline_mem_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
);
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic                  mem_req_write;
    logic [DATA_WIDTH-1:0] mem_req_wdata;
    logic [7:0]            mem_req_wstrb;
    logic                  mem_resp_valid;
    logic [DATA_WIDTH-1:0] mem_resp_rdata;

    modport master (
        output mem_req_valid, mem_req_addr, mem_req_write, mem_req_wdata, mem_req_wstrb,
        input  mem_req_ready, mem_resp_valid, mem_resp_rdata
    );

    modport slave (
        input  mem_req_valid, mem_req_addr, mem_req_write, mem_req_wdata, mem_req_wstrb,
        output mem_req_ready, mem_resp_valid, mem_resp_rdata
    );
endinterface

// File: rtl/pipeline_mem_align.sv
// Byte-lane alignment: store data/strobes, load extract+extend, misalignment check.
// Purely combinational; no handshake.
module mem_align
    import mem_pkg::*;
(
    input  mem_op_e     op_i,
    input  mem_size_e   size_i,
    input  logic [2:0]  addr_lo_i,
    input  logic [63:0] st_data_i,
    input  logic [63:0] ld_raw_i,
    output logic [63:0] st_data_o,
    output logic [7:0]  st_strb_o,
    output logic [63:0] ld_data_o,
    output logic        misaligned_o
);
    logic [3:0]  nb;
    logic [2:0]  align_mask;
    logic [7:0]  lane_mask;
    logic [5:0]  shamt;
    logic [63:0] shifted;
    logic        sext;

    always_comb begin
        nb         = size_bytes(size_i);
        align_mask = 3'(nb - 4'd1);
        lane_mask  = 8'((9'd1 << nb) - 9'd1);
        shamt      = {addr_lo_i, 3'b000};
        st_data_o  = st_data_i << shamt;
        st_strb_o  = lane_mask << addr_lo_i;
        shifted    = ld_raw_i >> shamt;
        sext       = (op_i == OP_LOAD);
        case (size_i)
            SZ_BYTE: ld_data_o = {{56{sext & shifted[7]}},  shifted[7:0]};
            SZ_HALF: ld_data_o = {{48{sext & shifted[15]}}, shifted[15:0]};
            SZ_WORD: ld_data_o = {{32{sext & shifted[31]}}, shifted[31:0]};
            default: ld_data_o = shifted;
        endcase
        misaligned_o = (op_i != OP_NONE) && ((addr_lo_i & align_mask) != 3'd0);
    end
endmodule

// File: rtl/pipeline_mem.sv
// Memory stage: registers EX result, one outstanding load/store, registered writeback.
// NONE/misaligned: 1 cycle; mem ops wait on req/resp handshakes; ready drops while busy or wb stalls.
module pipeline_mem
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  ready,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] ex_res,
    input  logic [DATA_WIDTH-1:0] r2_val_mem,
    input  logic [4:0]            mem_dst_reg,
    input  logic [31:0]           next_mem_opcode,
    input  logic [2:0]            next_mem_operation_size,
    input  logic                  ecall_mem,
    pipeline_mem_if.master        mem,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [4:0]            wb_dst_reg,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic                  wb_ecall,
    output logic                  wb_misaligned
);
    state_e          state_q, state_d;
    mem_op_e         op_q;
    mem_size_e       size_q;
    logic [63:0]     addr_q, r2_q, wb_data_q, wb_data_d;
    logic [4:0]      wb_dst_q, wb_dst_d;
    logic            ecall_q, mis_q;

    mem_op_e         in_op, al_op;
    mem_size_e       in_size, al_size;
    logic [2:0]      al_addr_lo;
    logic [63:0]     al_st_data, al_wdata, al_ld;
    logic [7:0]      al_wstrb;
    logic            al_mis, busy, accept, req_st, done_st;
    logic            unused_opc_hi;

    assign unused_opc_hi = ^next_mem_opcode[31:2];
    assign in_op         = mem_op_e'(next_mem_opcode[1:0]);
    assign in_size       = norm_size(next_mem_operation_size);

    // Aligner sees the incoming op when accepting and the held op while a transaction is in flight.
    assign busy       = (state_q == ST_REQ) || (state_q == ST_RESP);
    assign al_op      = busy ? op_q : in_op;
    assign al_size    = busy ? size_q : in_size;
    assign al_addr_lo = busy ? addr_q[2:0] : ex_res[2:0];
    assign al_st_data = busy ? r2_q : r2_val_mem;

    mem_align u_align (
        .op_i        (al_op),
        .size_i      (al_size),
        .addr_lo_i   (al_addr_lo),
        .st_data_i   (al_st_data),
        .ld_raw_i    (mem.mem_resp_rdata),
        .st_data_o   (al_wdata),
        .st_strb_o   (al_wstrb),
        .ld_data_o   (al_ld),
        .misaligned_o(al_mis)
    );

    assign ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && wb_ready);
    assign accept = in_valid && ready;

    always_comb begin
        state_d   = state_q;
        wb_data_d = wb_data_q;
        wb_dst_d  = wb_dst_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    state_d   = ((in_op == OP_NONE) || al_mis) ? ST_DONE : ST_REQ;
                    wb_data_d = ((in_op == OP_NONE) || al_mis) ? ex_res : 64'd0;
                    wb_dst_d  = (al_mis || (in_op == OP_STORE)) ? 5'd0 : mem_dst_reg;
                end else if (state_q == ST_DONE && wb_ready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem.mem_req_ready) begin
                    state_d = (op_q == OP_STORE) ? ST_DONE : ST_RESP;
                end
            end
            ST_RESP: begin
                if (mem.mem_resp_valid) begin
                    state_d   = ST_DONE;
                    wb_data_d = al_ld;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_NONE;
            size_q    <= SZ_BYTE;
            addr_q    <= 64'd0;
            r2_q      <= 64'd0;
            ecall_q   <= 1'b0;
            mis_q     <= 1'b0;
            wb_data_q <= 64'd0;
            wb_dst_q  <= 5'd0;
        end else begin
            state_q   <= state_d;
            wb_data_q <= wb_data_d;
            wb_dst_q  <= wb_dst_d;
            if (accept) begin
                op_q    <= in_op;
                size_q  <= in_size;
                addr_q  <= ex_res;
                r2_q    <= r2_val_mem;
                ecall_q <= ecall_mem;
                mis_q   <= al_mis;
            end
        end
    end

    // Outputs are forced to zero outside their owning state so idle/reset values are clean.
    assign req_st             = (state_q == ST_REQ);
    assign done_st            = (state_q == ST_DONE);
    assign mem.mem_req_valid  = req_st;
    assign mem.mem_req_addr   = req_st ? ADDR_WIDTH'({addr_q[63:3], 3'b000}) : '0;
    assign mem.mem_req_write  = req_st && (op_q == OP_STORE);
    assign mem.mem_req_wdata  = mem.mem_req_write ? al_wdata : 64'd0;
    assign mem.mem_req_wstrb  = mem.mem_req_write ? al_wstrb : 8'd0;

    assign wb_valid      = done_st;
    assign wb_data       = done_st ? wb_data_q : '0;
    assign wb_dst_reg    = done_st ? wb_dst_q : 5'd0;
    assign wb_ecall      = done_st && ecall_q;
    assign wb_misaligned = done_st && mis_q;
endmodule

// File: tb/tb_pipeline_mem.sv
// Bench for pipeline_mem: directed vector table, hand-written corner sequences, random ops vs model.
module tb_pipeline_mem;
    logic        clk = 1'b0;
    logic        reset;
    logic        ready, in_valid;
    logic [63:0] ex_res, r2_val_mem;
    logic [4:0]  mem_dst_reg;
    logic [31:0] next_mem_opcode;
    logic [2:0]  next_mem_operation_size;
    logic        ecall_mem;
    logic        wb_valid, wb_ready, wb_ecall, wb_misaligned;
    logic [4:0]  wb_dst_reg;
    logic [63:0] wb_data;

    always #5 clk = ~clk;

    pipeline_mem_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) mif ();

    pipeline_mem dut (
        .clk(clk), .reset(reset), .ready(ready), .in_valid(in_valid),
        .ex_res(ex_res), .r2_val_mem(r2_val_mem), .mem_dst_reg(mem_dst_reg),
        .next_mem_opcode(next_mem_opcode), .next_mem_operation_size(next_mem_operation_size),
        .ecall_mem(ecall_mem), .mem(mif),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_dst_reg(wb_dst_reg),
        .wb_data(wb_data), .wb_ecall(wb_ecall), .wb_misaligned(wb_misaligned)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [2:0]  sz;
        logic [63:0] addr, r2, rdata;
        logic [4:0]  dst;
        logic        e_req;
        logic [63:0] e_addr;
        logic [7:0]  e_wstrb;
        logic [63:0] e_wdata, e_wb;
        logic [4:0]  e_dst;
        logic        e_mis;
    } vec_t;

    vec_t vt [12];

    // Observations of one transaction through do_op.
    logic        r_req, r_write, r_timeout, r_mis, r_ec;
    logic [63:0] r_addr, r_wdata, r_wb;
    logic [7:0]  r_wstrb;
    logic [4:0]  r_dst;
    int          r_stab_bad, r_rdy_bad;

    task automatic do_op(input logic [1:0] op, input logic [2:0] sz, input logic [63:0] addr,
                         input logic [63:0] r2, input logic [63:0] rdata, input logic [4:0] dst,
                         input logic ec, input int req_lat, input int resp_lat);
        int hold = 0;
        int rw = 0;
        r_req = 0; r_stab_bad = 0; r_rdy_bad = 0; r_timeout = 1;
        r_addr = 0; r_wdata = 0; r_wstrb = 0; r_write = 0;
        r_wb = 0; r_dst = 0; r_mis = 0; r_ec = 0;
        @(negedge clk);
        in_valid = 1; next_mem_opcode = {30'($urandom), op}; next_mem_operation_size = sz;
        ex_res = addr; r2_val_mem = r2; mem_dst_reg = dst; ecall_mem = ec; wb_ready = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            in_valid = 0; mif.mem_req_ready = 0; mif.mem_resp_valid = 0;
            if (wb_valid) begin
                r_timeout = 0; r_wb = wb_data; r_dst = wb_dst_reg;
                r_mis = wb_misaligned; r_ec = wb_ecall;
                break;
            end
            if (ready) r_rdy_bad++;
            if (mif.mem_req_valid) begin
                if (!r_req) begin
                    r_addr = mif.mem_req_addr; r_wdata = mif.mem_req_wdata;
                    r_wstrb = mif.mem_req_wstrb; r_write = mif.mem_req_write;
                end else if (r_addr !== mif.mem_req_addr || r_wdata !== mif.mem_req_wdata ||
                             r_wstrb !== mif.mem_req_wstrb || r_write !== mif.mem_req_write) begin
                    r_stab_bad++;
                end
                r_req = 1;
                if (hold >= req_lat) mif.mem_req_ready = 1;
                else hold++;
            end else if (r_req) begin
                if (rw >= resp_lat) begin
                    mif.mem_resp_valid = 1; mif.mem_resp_rdata = rdata;
                end else begin
                    rw++; mif.mem_resp_rdata = {$urandom, $urandom};
                end
            end
        end
        mif.mem_req_ready = 0; mif.mem_resp_valid = 0;
        wb_ready = 1;
        @(negedge clk);
        wb_ready = 0;
    endtask

    task automatic check_res(input string nm, input logic [1:0] op, input logic e_req,
                             input logic [63:0] e_addr, input logic [7:0] e_wstrb,
                             input logic [63:0] e_wdata, input logic [63:0] e_wb,
                             input logic [4:0] e_dst, input logic e_mis, input logic ec);
        chk({nm, " timeout"}, 64'(r_timeout), 64'd0);
        chk({nm, " req_seen"}, 64'(r_req), 64'(e_req));
        if (e_req) begin
            chk({nm, " req_addr"}, r_addr, e_addr);
            chk({nm, " req_write"}, 64'(r_write), 64'(op == 2'd3));
            chk({nm, " req_stable"}, 64'(r_stab_bad), 64'd0);
            chk({nm, " ready_low_busy"}, 64'(r_rdy_bad), 64'd0);
        end
        if (e_req && op == 2'd3) begin
            chk({nm, " wstrb"}, 64'(r_wstrb), 64'(e_wstrb));
            chk({nm, " wdata"}, r_wdata, e_wdata);
        end
        chk({nm, " wb_data"}, r_wb, e_wb);
        chk({nm, " wb_dst"}, 64'(r_dst), 64'(e_dst));
        chk({nm, " wb_mis"}, 64'(r_mis), 64'(e_mis));
        chk({nm, " wb_ecall"}, 64'(r_ec), 64'(ec));
    endtask

    // Reference: byte-level arithmetic straight from the access rules.
    task automatic model(input logic [1:0] op, input logic [2:0] sz, input logic [63:0] addr,
                         input logic [63:0] r2, input logic [63:0] rdata, input logic [4:0] dst,
                         output logic e_req, output logic [63:0] e_addr, output logic [7:0] e_wstrb,
                         output logic [63:0] e_wdata, output logic [63:0] e_wb,
                         output logic [4:0] e_dst, output logic e_mis);
        int nb, lo, bits;
        logic [63:0] v, mask;
        nb   = 1 << ((sz > 3) ? 3 : int'(sz));
        lo   = int'(addr % 64'd8);
        bits = 8 * nb;
        e_mis  = (op != 0) && ((lo % nb) != 0);
        e_req  = (op != 0) && !e_mis;
        e_addr = addr - 64'(lo);
        e_wstrb = 0;
        for (int i = 0; i < 8; i++) if (i >= lo && i < lo + nb) e_wstrb[i] = 1'b1;
        e_wdata = r2 << (8 * lo);
        v = rdata >> (8 * lo);
        if (bits < 64) begin
            mask = (64'd1 << bits) - 64'd1;
            v = v & mask;
            if (op == 2'd1 && v[bits-1]) v = v | ~mask;
        end
        if (op == 0 || e_mis) e_wb = addr;
        else if (op == 2'd3) e_wb = 0;
        else e_wb = v;
        e_dst = (e_mis || op == 2'd3) ? 5'd0 : dst;
    endtask

    initial begin
        logic e_req, e_mis, ec;
        logic [63:0] e_addr, e_wdata, e_wb, a, r2, rd;
        logic [7:0]  e_wstrb;
        logic [4:0]  e_dst, dst;
        logic [1:0]  op;
        logic [2:0]  sz;

        vt[0]  = '{2'd0, 3'd0, 64'h1234, 64'h0, 64'h0, 5'd5, 1'b0, 64'h0, 8'h00, 64'h0, 64'h1234, 5'd5, 1'b0};
        vt[1]  = '{2'd3, 3'd1, 64'h1006, 64'hABCD, 64'h0, 5'd7, 1'b1, 64'h1000, 8'hC0, 64'hABCD_0000_0000_0000, 64'h0, 5'd0, 1'b0};
        vt[2]  = '{2'd1, 3'd0, 64'h2003, 64'h0, 64'h0000_0000_8000_0000, 5'd9, 1'b1, 64'h2000, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FF80, 5'd9, 1'b0};
        vt[3]  = '{2'd2, 3'd0, 64'h2003, 64'h0, 64'h0000_0000_8000_0000, 5'd9, 1'b1, 64'h2000, 8'h00, 64'h0, 64'h80, 5'd9, 1'b0};
        vt[4]  = '{2'd1, 3'd2, 64'h3002, 64'h0, 64'h0, 5'd4, 1'b0, 64'h0, 8'h00, 64'h0, 64'h3002, 5'd0, 1'b1};
        vt[5]  = '{2'd1, 3'd3, 64'h4000, 64'h0, 64'h8000_0000_0000_0001, 5'd3, 1'b1, 64'h4000, 8'h00, 64'h0, 64'h8000_0000_0000_0001, 5'd3, 1'b0};
        vt[6]  = '{2'd2, 3'd2, 64'h5004, 64'h0, 64'hDEAD_BEEF_0000_0000, 5'd2, 1'b1, 64'h5000, 8'h00, 64'h0, 64'hDEAD_BEEF, 5'd2, 1'b0};
        vt[7]  = '{2'd1, 3'd1, 64'h6006, 64'h0, 64'h8001_0000_0000_0000, 5'd1, 1'b1, 64'h6000, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_8001, 5'd1, 1'b0};
        vt[8]  = '{2'd3, 3'd2, 64'h7004, 64'h1122_3344, 64'h0, 5'd8, 1'b1, 64'h7000, 8'hF0, 64'h1122_3344_0000_0000, 64'h0, 5'd0, 1'b0};
        vt[9]  = '{2'd3, 3'd6, 64'h8001, 64'h55, 64'h0, 5'd8, 1'b0, 64'h0, 8'h00, 64'h0, 64'h8001, 5'd0, 1'b1};
        vt[10] = '{2'd3, 3'd5, 64'h9000, 64'h0102_0304_0506_0708, 64'h0, 5'd8, 1'b1, 64'h9000, 8'hFF, 64'h0102_0304_0506_0708, 64'h0, 5'd0, 1'b0};
        vt[11] = '{2'd0, 3'd3, 64'h13, 64'h0, 64'h0, 5'd6, 1'b0, 64'h0, 8'h00, 64'h0, 64'h13, 5'd6, 1'b0};

        reset = 0; in_valid = 0; ex_res = 0; r2_val_mem = 0; mem_dst_reg = 0;
        next_mem_opcode = 0; next_mem_operation_size = 0; ecall_mem = 0; wb_ready = 0;
        mif.mem_req_ready = 0; mif.mem_resp_valid = 0; mif.mem_resp_rdata = 0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst ready", 64'(ready), 64'd1);
        chk("rst req_valid", 64'(mif.mem_req_valid), 64'd0);
        chk("rst req_addr", mif.mem_req_addr, 64'd0);
        chk("rst req_wstrb", 64'(mif.mem_req_wstrb), 64'd0);
        chk("rst wb_valid", 64'(wb_valid), 64'd0);
        chk("rst wb_data", wb_data, 64'd0);
        chk("rst wb_misc", {59'd0, wb_dst_reg}, 64'd0);
        chk("rst wb_flags", {62'd0, wb_ecall, wb_misaligned}, 64'd0);
        reset = 1;

        // Back-to-back NONE ops at one per cycle
        @(negedge clk);
        wb_ready = 1; in_valid = 1; next_mem_opcode = 0; mem_dst_reg = 5;
        ex_res = 64'h1234;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("b2b%0d wb_valid", i), 64'(wb_valid), 64'd1);
            chk($sformatf("b2b%0d wb_data", i), wb_data, 64'h1234 + 64'(i));
            chk($sformatf("b2b%0d wb_dst", i), 64'(wb_dst_reg), 64'd5);
            ex_res = 64'h1235 + 64'(i);
            if (i == 2) in_valid = 0;
        end
        @(negedge clk);
        chk("b2b end wb_valid", 64'(wb_valid), 64'd0);
        wb_ready = 0;

        // Directed vector table
        for (int i = 0; i < 12; i++) begin
            ec = 1'(i);
            do_op(vt[i].op, vt[i].sz, vt[i].addr, vt[i].r2, vt[i].rdata, vt[i].dst, ec,
                  (i == 1) ? 3 : i % 2, (i == 2 || i == 3) ? 4 : i % 3);
            check_res($sformatf("vec%0d", i), vt[i].op, vt[i].e_req, vt[i].e_addr, vt[i].e_wstrb,
                      vt[i].e_wdata, vt[i].e_wb, vt[i].e_dst, vt[i].e_mis, ec);
        end

        // Writeback stall: DONE holds, no accept, then same-cycle accept on wb_ready
        @(negedge clk);
        in_valid = 1; next_mem_opcode = 0; ex_res = 64'hAAAA; mem_dst_reg = 3; wb_ready = 0;
        @(negedge clk);
        ex_res = 64'hBBBB; mem_dst_reg = 4;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall%0d ready", i), 64'(ready), 64'd0);
            chk($sformatf("stall%0d wb_valid", i), 64'(wb_valid), 64'd1);
            chk($sformatf("stall%0d wb_data", i), wb_data, 64'hAAAA);
            chk($sformatf("stall%0d wb_dst", i), 64'(wb_dst_reg), 64'd3);
            @(negedge clk);
        end
        wb_ready = 1;
        #1 chk("stall release ready", 64'(ready), 64'd1);
        @(negedge clk);
        chk("stall next wb_valid", 64'(wb_valid), 64'd1);
        chk("stall next wb_data", wb_data, 64'hBBBB);
        chk("stall next wb_dst", 64'(wb_dst_reg), 64'd4);
        in_valid = 0;
        @(negedge clk);
        chk("stall drain wb_valid", 64'(wb_valid), 64'd0);
        wb_ready = 0;

        // Reset while waiting for a load response; the late response must be dropped
        in_valid = 1; next_mem_opcode = 1; next_mem_operation_size = 3; ex_res = 64'h5000;
        mem_dst_reg = 2; mif.mem_req_ready = 1;
        @(negedge clk);
        in_valid = 0;
        chk("rresp req_valid", 64'(mif.mem_req_valid), 64'd1);
        @(negedge clk);
        mif.mem_req_ready = 0;
        chk("rresp in_resp ready", 64'(ready), 64'd0);
        reset = 0;
        @(negedge clk);
        reset = 1;
        chk("rresp after ready", 64'(ready), 64'd1);
        chk("rresp after req_valid", 64'(mif.mem_req_valid), 64'd0);
        mif.mem_resp_valid = 1; mif.mem_resp_rdata = 64'h1111_2222_3333_4444;
        @(negedge clk);
        mif.mem_resp_valid = 0;
        chk("rresp late wb_valid", 64'(wb_valid), 64'd0);
        chk("rresp late wb_data", wb_data, 64'd0);
        chk("rresp late ready", 64'(ready), 64'd1);
        @(negedge clk);
        chk("rresp late2 wb_valid", 64'(wb_valid), 64'd0);

        // Random ops against the reference model
        for (int n = 0; n < 150; n++) begin
            op = 2'($urandom_range(0, 3));
            sz = 3'($urandom_range(0, 7));
            a  = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) a[2:0] = 3'd0;
            r2 = {$urandom, $urandom};
            rd = {$urandom, $urandom};
            dst = 5'($urandom);
            ec = 1'($urandom);
            model(op, sz, a, r2, rd, dst, e_req, e_addr, e_wstrb, e_wdata, e_wb, e_dst, e_mis);
            do_op(op, sz, a, r2, rd, dst, ec, $urandom_range(0, 3), $urandom_range(0, 3));
            check_res($sformatf("rnd%0d", n), op, e_req, e_addr, e_wstrb, e_wdata, e_wb, e_dst, e_mis, ec);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
